ltc2324_axis_packer: RTL

Sits directly downstream of the LTC2324-16 4-channel ADC driver and feeds the Zynq SG-DMA S2MM channel. It captures each completed conversion (four 16-bit channels) into a 64-bit word and buffers it in a small FIFO. It emits the words as an AXI4-Stream with `tlast` every `PKT_LEN` samples, and reports dropped samples when the DMA back-pressures.

---
 rtl/adc_stream_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 84 ++++++++
 rtl/ltc2324_axis_packer.sv | 118 +++++++++++
 3 files changed

// File: rtl/adc_stream_pkg.sv
// Shared types for the ADC sample stream paths: channel widths, the packed
// four-channel sample, the FIFO word and the packet-state encoding.
package adc_stream_pkg;

  localparam int ADC_CH_W   = 16;
  localparam int ADC_NUM_CH = 4;
  localparam int SAMPLE_W   = ADC_CH_W * ADC_NUM_CH;

  typedef struct packed {
    logic [ADC_CH_W-1:0] ch4;
    logic [ADC_CH_W-1:0] ch3;
    logic [ADC_CH_W-1:0] ch2;
    logic [ADC_CH_W-1:0] ch1;
  } adc_sample_t;

  typedef struct packed {
    logic        last;
    adc_sample_t sample;
  } fifo_word_t;

  typedef enum logic {
    PKT_IDLE,
    PKT_ACTIVE
  } pkt_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through output stage.
// o_level counts every stored word, including the one held in the output stage.
module sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_data,
  input  logic                   i_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_mem_cnt;
  logic [AW:0]      r_level;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;

  logic w_push;
  logic w_pop;
  logic w_load;

  assign o_full  = (r_level == LVL_FULL);
  assign o_level = r_level;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

  assign w_push = i_push & ~o_full;
  assign w_pop  = r_out_valid & i_ready;
  // The output stage refills whenever it is empty or being drained this cycle.
  assign w_load = (r_mem_cnt != '0) & (~r_out_valid | i_ready);

  // NOTE: the storage array is deliberately not reset; pointers and counts alone decide which entries are live, so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: all state here updates with <= so every register samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_cnt   <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_load) r_rd_ptr <= r_rd_ptr + PTR_ONE;

      case ({w_push, w_load})
        2'b10:   r_mem_cnt <= r_mem_cnt + LVL_ONE;
        2'b01:   r_mem_cnt <= r_mem_cnt - LVL_ONE;
        default: r_mem_cnt <= r_mem_cnt;
      endcase

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase

      if (w_load) begin
        r_out_data  <= r_mem[r_rd_ptr];
        r_out_valid <= 1'b1;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ltc2324_axis_packer.sv
// Packs LTC2324-16 conversions into 64-bit AXI4-Stream words framed into
// PKT_LEN-sample packets, counting samples dropped under DMA back-pressure.
module ltc2324_axis_packer
  import adc_stream_pkg::*;
#(
  parameter int PKT_LEN    = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stream_en,
  input  logic                          clr_status,
  input  logic                          adc_valid,
  input  logic [ADC_CH_W-1:0]           adc_ch1,
  input  logic [ADC_CH_W-1:0]           adc_ch2,
  input  logic [ADC_CH_W-1:0]           adc_ch3,
  input  logic [ADC_CH_W-1:0]           adc_ch4,
  output logic [SAMPLE_W-1:0]           m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          overflow,
  output logic [15:0]                   drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

  logic       r_valid_q;
  logic       r_armed;
  pkt_state_t r_state;
  pkt_state_t w_state_nxt;
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_drop_cnt;
  logic        r_overflow;

  logic       w_capture;
  logic       w_at_last;
  logic       w_take;
  logic       w_push;
  logic       w_drop;
  logic       w_full;
  fifo_word_t w_wr_word;
  fifo_word_t w_rd_word;

  // r_armed keeps a valid pulse that straddles reset release from counting as a new conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_q <= 1'b0;
      r_armed   <= ~adc_valid;
    end else begin
      r_valid_q <= adc_valid;
      if (!adc_valid) r_armed <= 1'b1;
    end
  end

  assign w_capture = adc_valid & ~r_valid_q & r_armed;
  assign w_at_last = (r_pkt_cnt == LAST_IDX);
  assign w_wr_word = {w_at_last, adc_ch4, adc_ch3, adc_ch2, adc_ch1};

  always_ff @(posedge clk) begin
    if (rst) r_state <= PKT_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PKT_IDLE:   if (w_capture && stream_en) w_state_nxt = PKT_ACTIVE;
      PKT_ACTIVE: if (w_push && w_at_last && !stream_en) w_state_nxt = PKT_IDLE;
      default:    w_state_nxt = PKT_IDLE;
    endcase
  end

  always_comb begin
    w_take = w_capture && ((r_state == PKT_ACTIVE) || stream_en);
    w_push = w_take && !w_full;
    w_drop = w_take && w_full;
  end

  // Drops leave the packet counter alone so every packet holds exactly PKT_LEN words.
  always_ff @(posedge clk) begin
    if (rst)         r_pkt_cnt <= '0;
    else if (w_push) r_pkt_cnt <= w_at_last ? 16'd0 : r_pkt_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_status) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fifo_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_wr_word),
    .o_full  (w_full),
    .o_level (fifo_level),
    .o_valid (m_axis_tvalid),
    .o_data  (w_rd_word),
    .i_ready (m_axis_tready)
  );

  assign m_axis_tdata = w_rd_word.sample;
  assign m_axis_tlast = w_rd_word.last;
  assign overflow     = r_overflow;
  assign drop_cnt     = r_drop_cnt;

endmodule
